// File: rtl/fir_decimate.sv
// fir_decimate: streaming decimating FIR filter.
// It shifts DECIMATION new Q10 samples into a TAPS-deep delay line, then
// accumulates one dequantized tap product per cycle. The finished sum is
// pushed to the downstream FIFO, giving one output per DECIMATION inputs.
module fir_decimate #(
  parameter int DATA_WIDTH = 32,
  parameter int TAPS       = 32,
  parameter int DECIMATION = 8,
  parameter logic signed [DATA_WIDTH-1:0] COEFFS [TAPS] = '{default: '0}
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_dout,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] out_din,
  input  logic                  out_full,
  output logic                  out_wr_en
);

  localparam int CNT_W = $clog2(DECIMATION + 1);
  localparam int TAP_W = $clog2(TAPS);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(DECIMATION - 1);
  localparam logic [TAP_W-1:0] LAST_TAP   = TAP_W'(TAPS - 1);
  localparam logic signed [DATA_WIDTH-1:0] ROUND_BIAS = DATA_WIDTH'(1023);

  typedef enum logic [1:0] {
    S_SHIFT = 2'd0,
    S_MAC   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  // Q10 dequantize: arithmetic shift by 10 bits, rounding toward zero.
  // Negative values get a bias of 2^10-1 so the floor shift truncates
  // toward zero instead of toward minus infinity.
  function automatic logic signed [DATA_WIDTH-1:0] dequant(
    input logic signed [DATA_WIDTH-1:0] p
  );
    logic signed [DATA_WIDTH-1:0] biased;
    if (p[DATA_WIDTH-1]) begin
      biased = p + ROUND_BIAS;
    end else begin
      biased = p;
    end
    return biased >>> 10;
  endfunction

  state_t                       state_q, state_d;
  logic [CNT_W-1:0]             shift_cnt_q, shift_cnt_d;
  logic [TAP_W-1:0]             tap_idx_q, tap_idx_d;
  logic signed [DATA_WIDTH-1:0] acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0] out_din_q, out_din_d;
  logic signed [DATA_WIDTH-1:0] x_q [TAPS];
  logic signed [DATA_WIDTH-1:0] x_d [TAPS];

  logic signed [DATA_WIDTH-1:0] prod_s;
  logic signed [DATA_WIDTH-1:0] mac_sum_s;
  logic                         rd_en_s;
  logic                         wr_en_s;

  // Current tap product (low DATA_WIDTH bits) and the accumulator update.
  always_comb begin
    prod_s    = COEFFS[tap_idx_q] * x_q[tap_idx_q];
    mac_sum_s = acc_q + dequant(prod_s);
  end

  // Next-state logic: sample shifting, MAC sequencing and output handshake.
  always_comb begin
    state_d     = state_q;
    shift_cnt_d = shift_cnt_q;
    tap_idx_d   = tap_idx_q;
    acc_d       = acc_q;
    out_din_d   = out_din_q;
    x_d         = x_q;
    rd_en_s     = 1'b0;
    wr_en_s     = 1'b0;

    case (state_q)
      S_SHIFT: begin
        rd_en_s = !in_empty;
        if (!in_empty) begin
          for (int i = TAPS - 1; i > 0; i--) begin
            x_d[i] = x_q[i-1];
          end
          x_d[0] = in_dout;
          if (shift_cnt_q == LAST_SHIFT) begin
            shift_cnt_d = '0;
            acc_d       = '0;
            tap_idx_d   = '0;
            state_d     = S_MAC;
          end else begin
            shift_cnt_d = shift_cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = S_SHIFT;
        end
      end

      S_MAC: begin
        acc_d = mac_sum_s;
        if (tap_idx_q == LAST_TAP) begin
          tap_idx_d = '0;
          out_din_d = mac_sum_s;
          state_d   = S_WRITE;
        end else begin
          tap_idx_d = tap_idx_q + TAP_W'(1);
        end
      end

      S_WRITE: begin
        // The strobe is qualified by the live full flag so a FIFO that
        // fills in this very cycle is never overrun; out_din is held.
        if (!out_full) begin
          wr_en_s = 1'b1;
          state_d = S_SHIFT;
        end else begin
          state_d = S_WRITE;
        end
      end

      default: begin
        state_d = S_SHIFT;
      end
    endcase
  end

  // State, counters, accumulator, output data and delay line registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_SHIFT;
      shift_cnt_q <= '0;
      tap_idx_q   <= '0;
      acc_q       <= '0;
      out_din_q   <= '0;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      shift_cnt_q <= shift_cnt_d;
      tap_idx_q   <= tap_idx_d;
      acc_q       <= acc_d;
      out_din_q   <= out_din_d;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= x_d[i];
      end
    end
  end

  assign in_rd_en  = rd_en_s & reset_n;
  assign out_wr_en = wr_en_s;
  assign out_din   = out_din_q;

endmodule

// File: tb/tb_fir_decimate.sv
// Scoreboard bench for fir_decimate: two instances (unity-gain 4-tap
// averager and a rounding probe). Stimulus pushes expected outputs into
// queues; per-instance monitors pop and compare on every write strobe.
module tb_fir_decimate;

  localparam logic signed [31:0] CA [4] = '{32'sd1024, 32'sd1024, 32'sd1024, 32'sd1024};
  localparam logic signed [31:0] CB [4] = '{32'sd1, 32'sd0, 32'sd0, 32'sd0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int wr_cnt_a   = 0;
  int wr_cnt_b   = 0;
  int wr_cyc_a   = 0;
  int read_cyc   = 0;

  logic               rst_a_n, rst_b_n;
  logic signed [31:0] a_dout, b_dout;
  logic               a_empty, b_empty, a_full, b_full;
  logic               a_rd, b_rd, a_wr, b_wr;
  logic [31:0]        a_din, b_din;

  logic signed [31:0] exp_a [$];
  logic signed [31:0] exp_b [$];

  fir_decimate #(.DATA_WIDTH(32), .TAPS(4), .DECIMATION(2), .COEFFS(CA)) dut_a (
    .clock(clk), .reset_n(rst_a_n), .in_dout(a_dout), .in_empty(a_empty),
    .in_rd_en(a_rd), .out_din(a_din), .out_full(a_full), .out_wr_en(a_wr)
  );

  fir_decimate #(.DATA_WIDTH(32), .TAPS(4), .DECIMATION(2), .COEFFS(CB)) dut_b (
    .clock(clk), .reset_n(rst_b_n), .in_dout(b_dout), .in_empty(b_empty),
    .in_rd_en(b_rd), .out_din(b_din), .out_full(b_full), .out_wr_en(b_wr)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor A: compares every write against the scoreboard queue.
  always @(negedge clk) begin
    #2;
    if (a_wr === 1'b1) begin
      wr_cnt_a++;
      wr_cyc_a = cyc;
      check("a_rd_wr_exclusive", 32'(a_rd), 32'sd0);
      if (exp_a.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL a_unexpected_write: got %0d, expected no write", $signed(a_din));
      end else begin
        check("a_out_din", a_din, exp_a.pop_front());
      end
    end
  end

  // Monitor B: same checks for the rounding instance.
  always @(negedge clk) begin
    #2;
    if (b_wr === 1'b1) begin
      wr_cnt_b++;
      check("b_rd_wr_exclusive", 32'(b_rd), 32'sd0);
      if (exp_b.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL b_unexpected_write: got %0d, expected no write", $signed(b_din));
      end else begin
        check("b_out_din", b_din, exp_b.pop_front());
      end
    end
  end

  // Offer one sample and wait (bounded) until it is popped; ends at a negedge.
  task automatic push(input bit sel, input logic signed [31:0] v);
    int n = 0;
    if (sel == 1'b0) begin a_dout = v; a_empty = 1'b0; end
    else begin b_dout = v; b_empty = 1'b0; end
    #1;
    while ((((sel == 1'b0) ? a_rd : b_rd) !== 1'b1) && n < 100) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 100) begin
      compared++;
      mismatched++;
      $display("FAIL push_timeout: got no read, expected read of %0d", v);
    end else begin
      read_cyc = cyc;
    end
    @(negedge clk);
    if (sel == 1'b0) a_empty = 1'b1; else b_empty = 1'b1;
  endtask

  // Wait (bounded) until the scoreboard queue has drained; ends at a negedge.
  task automatic wait_drain(input bit sel);
    int n = 0;
    while ((((sel == 1'b0) ? exp_a.size() : exp_b.size()) != 0) && n < 300) begin
      @(negedge clk); #3; n++;
    end
    if (n >= 300) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got %0d pending, expected 0",
               (sel == 1'b0) ? exp_a.size() : exp_b.size());
    end
    @(negedge clk);
  endtask

  task automatic pulse_reset_a();
    rst_a_n = 1'b0;
    @(negedge clk);
    rst_a_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int cnt0;
    logic signed [31:0] hist [4];
    logic signed [31:0] v;

    rst_a_n = 1'b0; rst_b_n = 1'b0;
    a_dout = '0; b_dout = '0;
    a_empty = 1'b0; b_empty = 1'b0;
    a_full = 1'b0; b_full = 1'b0;

    // Reset values with a non-empty upstream FIFO.
    #23;
    check("reset_a_rd_en", 32'(a_rd), 32'sd0);
    check("reset_a_wr_en", 32'(a_wr), 32'sd0);
    check("reset_a_out_din", a_din, 32'sd0);
    check("reset_b_rd_en", 32'(b_rd), 32'sd0);
    check("reset_b_wr_en", 32'(b_wr), 32'sd0);
    check("reset_b_out_din", b_din, 32'sd0);
    @(negedge clk);
    a_empty = 1'b1; b_empty = 1'b1;
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    @(negedge clk);

    // Basic filtering and latency.
    exp_a.push_back(32'sd3072);
    push(1'b0, 32'sd1024);
    push(1'b0, 32'sd2048);
    t = read_cyc;
    wait_drain(1'b0);
    check("a_latency", wr_cyc_a - t, 32'sd5);
    exp_a.push_back(32'sd10240);
    push(1'b0, 32'sd3072);
    push(1'b0, 32'sd4096);
    wait_drain(1'b0);

    // Rounding toward zero on the second instance.
    exp_b.push_back(-32'sd1);
    push(1'b1, -32'sd5);
    push(1'b1, -32'sd1025);
    wait_drain(1'b1);
    exp_b.push_back(32'sd0);
    push(1'b1, 32'sd0);
    push(1'b1, -32'sd1);
    wait_drain(1'b1);

    // Output backpressure: history 4096,3072 plus 5,6 sums to 7179.
    cnt0 = wr_cnt_a;
    a_full = 1'b1;
    exp_a.push_back(32'sd7179);
    push(1'b0, 32'sd5);
    push(1'b0, 32'sd6);
    a_dout = 32'sd999;
    a_empty = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 check("a_mac_no_read", 32'(a_rd), 32'sd0);
      @(negedge clk);
    end
    for (int i = 0; i < 10; i++) begin
      #1;
      check("a_stall_wr_en", 32'(a_wr), 32'sd0);
      check("a_stall_rd_en", 32'(a_rd), 32'sd0);
      @(negedge clk);
    end
    a_full = 1'b0;
    #1 check("a_release_wr_en", 32'(a_wr), 32'sd1);
    @(negedge clk);
    a_empty = 1'b1;
    wait_drain(1'b0);
    repeat (5) @(negedge clk);
    check("a_stall_write_count", wr_cnt_a - cnt0, 32'sd1);

    // Reset mid-MAC: partial result dropped, history cleared.
    push(1'b0, 32'sd7);
    push(1'b0, 32'sd8);
    @(negedge clk);
    rst_a_n = 1'b0;
    a_empty = 1'b0;
    #1;
    check("a_midreset_rd_en", 32'(a_rd), 32'sd0);
    check("a_midreset_wr_en", 32'(a_wr), 32'sd0);
    @(negedge clk);
    a_empty = 1'b1;
    rst_a_n = 1'b1;
    repeat (10) @(negedge clk);
    exp_a.push_back(32'sd3072);
    push(1'b0, 32'sd1024);
    push(1'b0, 32'sd2048);
    wait_drain(1'b0);

    // Input gaps over 1000 samples from a clean delay line.
    pulse_reset_a();
    for (int i = 0; i < 4; i++) hist[i] = '0;
    cnt0 = wr_cnt_a;
    for (int i = 0; i < 1000; i++) begin
      v = 32'((i * 37) % 401) - 32'sd200;
      hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = v;
      if (i % 2 == 1) exp_a.push_back(hist[0] + hist[1] + hist[2] + hist[3]);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      push(1'b0, v);
    end
    wait_drain(1'b0);
    check("a_gap_output_count", wr_cnt_a - cnt0, 32'sd500);

    check("a_queue_left", exp_a.size(), 32'sd0);
    check("b_queue_left", exp_b.size(), 32'sd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
